// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader_pkg : shared types and frame constants for the UART program loader
// Revision: 1.0
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         COUNT_W           = 16;
  localparam int         BYTES_PER_WORD    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_byte : 8N1 receiver with 2-flop input synchroniser and mid-bit sampling
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int                TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF_M1 = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_M1 = TIMER_W'(CLKS_PER_BIT - 1);

  logic               rx_meta;
  logic               rx_sync;
  logic               rx_prev;
  rx_state_t          state;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         bit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (timer == HALF_M1) begin
            timer <= '0;
            // a start bit that is high again at mid-bit was only a glitch
            state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (timer == FULL_M1) begin
            timer   <= '0;
            data    <= {rx_sync, data[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (timer == FULL_M1) begin
            timer      <= '0;
            byte_valid <= rx_sync;
            frame_err  <= !rx_sync;
            state      <= RX_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_uart_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_uart_loader : frames UART bytes into 32-bit words and writes instruction memory
// Revision: 1.0
// ---------------------------------------------------------------------------
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         ADDR_W       = 8,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [COUNT_W:0] MAX_WORDS = (COUNT_W + 1)'(2 ** ADDR_W);
  localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [7:0]         rx_data;
  logic               byte_valid;
  logic               frame_err;

  loader_state_t      state;
  logic [COUNT_W-1:0] count;
  logic [7:0]         chk;
  logic [23:0]        word;
  logic [1:0]         byte_idx;

  logic [COUNT_W-1:0] count_full;
  logic [ADDR_W:0]    words_next;
  logic [7:0]         chk_next;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (rx_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign count_full = {rx_data, count[7:0]};
  assign words_next = words_loaded + (ADDR_W + 1)'(1);
  assign chk_next   = chk ^ rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      count        <= '0;
      chk          <= '0;
      word         <= '0;
      byte_idx     <= '0;
      mem_wren     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_wren <= 1'b0;
      if (frame_err && state != ST_IDLE) begin
        load_err <= 1'b1;
        cpu_hold <= 1'b0;
        state    <= ST_IDLE;
      end else if (byte_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state        <= ST_CNT_LO;
              cpu_hold     <= 1'b1;
              load_done    <= 1'b0;
              load_err     <= 1'b0;
              words_loaded <= '0;
              chk          <= '0;
              byte_idx     <= '0;
            end
          end
          ST_CNT_LO: begin
            count[7:0] <= rx_data;
            chk        <= chk_next;
            state      <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            count <= count_full;
            chk   <= chk_next;
            if ({1'b0, count_full} > MAX_WORDS) begin
              load_err <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= ST_IDLE;
            end else if (count_full == '0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            chk      <= chk_next;
            byte_idx <= byte_idx + 1'b1;
            word     <= {rx_data, word[23:8]};
            if (byte_idx == LAST_BYTE) begin
              mem_wren     <= 1'b1;
              mem_addr     <= words_loaded[ADDR_W-1:0];
              mem_wdata    <= {rx_data, word};
              words_loaded <= words_next;
              if ((COUNT_W + 1)'(words_next) == (COUNT_W + 1)'(count)) state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (rx_data == chk) load_done <= 1'b1;
            else                load_err  <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_imem_uart_loader : table-driven and randomized frames against a frame-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_imem_uart_loader;

  localparam int CPB = 4;
  localparam int AW  = 8;
  localparam int P   = 12 * CPB;  // byte period on the line: 10 bits + 2 idle bits

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  imem_uart_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .mem_wren     (mem_wren),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            hold_cycles = 0;
  int            rx_events   = 0;

  always @(negedge clk) begin
    if (mem_wren) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (cpu_hold) hold_cycles++;
    if (dut.u_rx.byte_valid || dut.u_rx.frame_err) rx_events++;
  end

  logic [31:0] frame_words[8];

  typedef struct {
    int cnt;
    bit flip;
    int stop_at;
    bit done;
    bit err;
    int wl;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (P - 10 * CPB) @(negedge clk);
  endtask

  // Frame = SYNC, CNT_LO, CNT_HI, data bytes, CHK; oversize counts send only the header.
  task automatic send_frame(input int cnt, input bit flip, input int stop_at, output int n_sent);
    logic [7:0] bytes[$];
    logic [7:0] x;
    logic [15:0] c16;
    logic [31:0] w;
    c16 = cnt[15:0];
    bytes.push_back(8'hA5);
    bytes.push_back(c16[7:0]);
    bytes.push_back(c16[15:8]);
    x = c16[7:0] ^ c16[15:8];
    if (cnt <= 256) begin
      for (int i = 0; i < cnt; i++) begin
        w = frame_words[i];
        for (int k = 0; k < 4; k++) begin
          bytes.push_back(w[8*k +: 8]);
          x = x ^ w[8*k +: 8];
        end
      end
      bytes.push_back(x ^ {7'd0, flip});
    end
    n_sent = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      if (stop_at >= 0 && i > stop_at) break;
      send_byte(bytes[i], !(i == stop_at));
      n_sent++;
    end
  endtask

  function automatic void model(input int cnt, input bit flip, input int stop_at,
                                output bit d, output bit e, output int wl);
    d = 1'b0; e = 1'b0; wl = 0;
    if (stop_at >= 0) begin
      e = 1'b1;
      for (int i = 0; i < cnt && cnt <= 256; i++)
        if (3 + 4 * i + 3 < stop_at) wl = i + 1;
    end else if (cnt > 256) begin
      e = 1'b1;
    end else begin
      wl = cnt;
      d  = !flip;
      e  = flip;
    end
  endfunction

  task automatic run_case(input int cnt, input bit flip, input int stop_at,
                          input bit ed, input bit ee, input int ewl, input string tag);
    int wbase, hbase, ns, nw;
    wbase = wr_addr_q.size();
    hbase = hold_cycles;
    send_frame(cnt, flip, stop_at, ns);
    repeat (4) @(negedge clk);
    check({tag, ".load_done"}, 64'(load_done), 64'(ed));
    check({tag, ".load_err"}, 64'(load_err), 64'(ee));
    check({tag, ".words_loaded"}, 64'(words_loaded), 64'(ewl));
    check({tag, ".cpu_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, ".hold_cycles"}, 64'(hold_cycles - hbase), 64'((ns - 1) * P));
    nw = wr_addr_q.size() - wbase;
    check({tag, ".n_writes"}, 64'(nw), 64'(ewl));
    for (int i = 0; i < ewl && i < nw; i++) begin
      check($sformatf("%s.addr%0d", tag, i), 64'(wr_addr_q[wbase + i]), 64'(i));
      check($sformatf("%s.data%0d", tag, i), 64'(wr_data_q[wbase + i]), 64'(frame_words[i]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_wren"}, 64'(mem_wren), 64'd0);
    check({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, ".cpu_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, ".load_done"}, 64'(load_done), 64'd0);
    check({tag, ".load_err"}, 64'(load_err), 64'd0);
    check({tag, ".words_loaded"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    int  nw_before, ev_before, ns, cnt, se;
    bit  flip, ed, ee;
    int  ewl;

    vecs[0] = '{cnt: 2,   flip: 1'b0, stop_at: -1, done: 1'b1, err: 1'b0, wl: 2};
    vecs[1] = '{cnt: 2,   flip: 1'b1, stop_at: -1, done: 1'b0, err: 1'b1, wl: 2};
    vecs[2] = '{cnt: 0,   flip: 1'b0, stop_at: -1, done: 1'b1, err: 1'b0, wl: 0};
    vecs[3] = '{cnt: 257, flip: 1'b0, stop_at: -1, done: 1'b0, err: 1'b1, wl: 0};
    vecs[4] = '{cnt: 2,   flip: 1'b0, stop_at: 4,  done: 1'b0, err: 1'b1, wl: 0};
    vecs[5] = '{cnt: 3,   flip: 1'b0, stop_at: -1, done: 1'b1, err: 1'b0, wl: 3};

    frame_words[0] = 32'hE3A00001;
    frame_words[1] = 32'hE3A0100A;
    frame_words[2] = 32'hDEADBEEF;
    frame_words[3] = 32'h01234567;
    for (int i = 4; i < 8; i++) frame_words[i] = 32'h0;

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_case(vecs[v].cnt, vecs[v].flip, vecs[v].stop_at,
               vecs[v].done, vecs[v].err, vecs[v].wl, $sformatf("vec%0d", v));

    // reset during the 3rd data byte of word 0
    nw_before = wr_addr_q.size();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    check("midrst.hold_before", 64'(cpu_hold), 64'd1);
    fork
      send_byte(8'hA0, 1'b1);
      begin
        repeat (4 * CPB) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
      end
    join
    repeat (2 * P) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("after_rst");
    check("midrst.n_writes", 64'(wr_addr_q.size() - nw_before), 64'd0);

    // one-cycle low glitch while idle
    ev_before = rx_events;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    check("glitch.rx_events", 64'(rx_events - ev_before), 64'd0);
    check("glitch.cpu_hold", 64'(cpu_hold), 64'd0);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 8; i++) frame_words[i] = $urandom;
      cnt  = ($urandom_range(0, 7) == 0) ? 257 + $urandom_range(0, 300) : $urandom_range(0, 6);
      flip = ($urandom_range(0, 2) == 0);
      se   = -1;
      if ($urandom_range(0, 3) == 0)
        se = (cnt > 256) ? $urandom_range(1, 2) : $urandom_range(1, 3 + 4 * cnt);
      model(cnt, flip, se, ed, ee, ewl);
      run_case(cnt, flip, se, ed, ee, ewl, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
